// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed UART boot loader: sync/length/words/XOR checksum, one-entry write port, CPU reset hold
module uart_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        hold_cpu
);
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_FINISH} state_t;

    // gap_cnt holds the number of edges since the last strobe, so it reaches
    // TIMEOUT_CYCLES on the edge that raises err
    localparam logic [31:0] GAP_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  len_lo, acc;
    logic [15:0] word_cnt, word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] gap_cnt;
    logic        sync_pending;

    logic        mem_we_d, busy_d, done_d, err_d, hold_d;
    logic [31:0] mem_addr_d, mem_wdata_d;

    logic is_sync, write_busy, start, timed_out, word_end, last_word;

    assign is_sync    = rx_data_valid && (rx_data == SYNC_BYTE);
    assign write_busy = mem_we && !mem_ready;
    assign start      = is_sync || sync_pending;
    assign timed_out  = (state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM}) &&
                        !rx_data_valid && (gap_cnt == GAP_LAST);
    assign word_end   = (state == S_DATA) && rx_data_valid && (byte_cnt == 2'd3);
    assign last_word  = (word_idx == word_cnt - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            hold_cpu  <= 1'b1;
        end else begin
            state     <= state_next;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            hold_cpu  <= hold_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LEN0;
            S_LEN0: begin
                if (timed_out)          state_next = S_IDLE;
                else if (rx_data_valid) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (timed_out) state_next = S_IDLE;
                else if (rx_data_valid)
                    state_next = ({rx_data, len_lo} != 16'd0) ? S_DATA : S_CSUM;
            end
            S_DATA: begin
                if (timed_out)       state_next = S_IDLE;
                else if (word_end) begin
                    if (write_busy)     state_next = S_IDLE;
                    else if (last_word) state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (timed_out) state_next = S_IDLE;
                else if (rx_data_valid)
                    state_next = (rx_data == acc && write_busy) ? S_FINISH : S_IDLE;
            end
            S_FINISH: if (!write_busy) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we_d    = write_busy;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        done_d      = 1'b0;
        err_d       = err;
        hold_d      = hold_cpu;
        busy_d      = (state_next != S_IDLE);
        if (timed_out) err_d = 1'b1;
        case (state)
            S_IDLE: if (start) begin
                err_d  = 1'b0;
                hold_d = 1'b1;
            end
            S_DATA: if (word_end) begin
                if (write_busy) begin
                    err_d = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + {14'd0, word_idx, 2'b00};
                    mem_wdata_d = {rx_data, shift};
                end
            end
            S_CSUM: if (rx_data_valid) begin
                if (rx_data != acc) begin
                    err_d = 1'b1;
                end else if (!write_busy) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end
            end
            S_FINISH: if (!write_busy) begin
                done_d = 1'b1;
                hold_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo       <= 8'd0;
            acc          <= 8'd0;
            word_cnt     <= 16'd0;
            word_idx     <= 16'd0;
            byte_cnt     <= 2'd0;
            shift        <= 24'd0;
            gap_cnt      <= 32'd0;
            sync_pending <= 1'b0;
        end else begin
            if (rx_data_valid)
                gap_cnt <= 32'd1;
            else if (state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM})
                gap_cnt <= gap_cnt + 32'd1;
            else
                gap_cnt <= 32'd0;

            // a sync seen while the last write drains starts the next frame right after done
            sync_pending <= (state == S_FINISH) ? (sync_pending || is_sync) : 1'b0;

            case (state)
                S_IDLE: if (start) begin
                    word_idx <= 16'd0;
                    acc      <= 8'd0;
                    byte_cnt <= 2'd0;
                end
                S_LEN0: if (rx_data_valid) len_lo <= rx_data;
                S_LEN1: if (rx_data_valid) word_cnt <= {rx_data, len_lo};
                S_DATA: if (rx_data_valid) begin
                    shift    <= {rx_data, shift[23:8]};
                    acc      <= acc ^ rx_data;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) word_idx <= word_idx + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - table, hand-written and random frames for uart_loader against a frame-level model
module tb_uart_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b1;
    logic        busy, done, err, hold_cpu;

    uart_loader #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(1000), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst(rst), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err), .hold_cpu(hold_cpu)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // write-port driver: optional forced stall on the next write, otherwise random ready
    int stall_req = 0;
    int stall_tag = 0;
    int tag_seen = 0;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        if (stall_tag != tag_seen) begin
            tag_seen = stall_tag;
            stall_left = stall_req;
        end
        if (stall_left > 0) begin
            mem_ready = 1'b0;
            if (mem_we) stall_left--;
        end else begin
            mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: accepted writes, done pulses, stability of held requests
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          done_count = 0;
    int          unstable = 0;
    int          stall_seen = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_a = 32'd0, prev_d = 32'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                stall_seen++;
                if (!mem_we || mem_addr !== prev_a || mem_wdata !== prev_d) unstable++;
            end
            if (mem_we && mem_ready) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
            end
            if (done) done_count++;
            prev_pend = mem_we && !mem_ready;
            prev_a = mem_addr;
            prev_d = mem_wdata;
        end
    end

    // frame-level reference: locate sync, read length, assemble words, XOR all data bytes
    logic [7:0]  frame[$];
    logic [31:0] exp_words[$];
    bit          exp_ok;
    int          sync_pos;

    function automatic void model();
        int p;
        int n;
        logic [7:0] x;
        exp_words.delete();
        sync_pos = 0;
        while (frame[sync_pos] != SYNC) sync_pos++;
        n = int'(frame[sync_pos + 1]) + 256 * int'(frame[sync_pos + 2]);
        p = sync_pos + 3;
        x = 8'd0;
        for (int w = 0; w < n; w++) begin
            exp_words.push_back({frame[p + 3], frame[p + 2], frame[p + 1], frame[p]});
            x = x ^ frame[p] ^ frame[p + 1] ^ frame[p + 2] ^ frame[p + 3];
            p += 4;
        end
        exp_ok = (frame[p] == x);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data_valid = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input int exp_writes, input int exp_done,
                             input logic exp_err, input logic exp_hold);
        int base;
        int d0;
        bit settled;
        base = got_data.size();
        d0 = done_count;
        for (int k = 0; k < frame.size(); k++) begin
            send_byte(frame[k]);
            if (k == sync_pos) begin
                check({name, "_hold_on_sync"}, hold_cpu, 1);
                check({name, "_busy_on_sync"}, busy, 1);
                check({name, "_err_clr_on_sync"}, err, 0);
            end
            idle(7);
        end
        settled = 0;
        for (int c = 0; c < 200 && !settled; c++) begin
            @(posedge clk); #1;
            if (!busy && !mem_we) settled = 1;
        end
        check({name, "_settle"}, settled, 1);
        check({name, "_write_count"}, got_data.size() - base, exp_writes);
        for (int w = 0; w < exp_words.size() && base + w < got_data.size(); w++) begin
            check({name, "_addr"}, got_addr[base + w], BASE + 32'(4 * w));
            check({name, "_data"}, got_data[base + w], exp_words[w]);
        end
        check({name, "_done_pulses"}, done_count - d0, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_hold"}, hold_cpu, exp_hold);
        check({name, "_stable"}, unstable, 0);
    endtask

    typedef struct {
        logic [127:0] bytes;
        int           len;
        int           exp_writes;
        int           exp_done;
        logic         exp_err;
        logic         exp_hold;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;
    vec_t vecs[5];

    task automatic load_vec(input int i);
        frame.delete();
        for (int k = 0; k < vecs[i].len; k++)
            frame.push_back(vecs[i].bytes[8 * (vecs[i].len - 1 - k) +: 8]);
        model();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          base;
        int          sb;
        int          n;
        int          g;
        logic [7:0]  x;
        logic [7:0]  b;

        vecs[0] = '{128'hA5_02_00_78_56_34_12_EF_BE_AD_DE_2A, 12, 2, 1, 1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF};
        vecs[1] = '{128'hA5_02_00_78_56_34_12_EF_BE_AD_DE_2B, 12, 2, 0, 1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{128'h00_FF_5A_A5_00_00_00,                7, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{128'hA5_01_00_11_22_33_44_44,             8, 1, 1, 1'b0, 1'b0, 32'h44332211, 32'h0};
        vecs[4] = '{128'hA5_00_00_01,                         4, 0, 0, 1'b1, 1'b1, 32'h0, 32'h0};

        #2 rst = 1'b1;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_hold", hold_cpu, 1);
        @(posedge clk); #1 rst = 1'b0;
        idle(3);

        for (int i = 0; i < 5; i++) begin
            load_vec(i);
            base = got_data.size();
            run_frame($sformatf("vec%0d", i), vecs[i].exp_writes, vecs[i].exp_done,
                      vecs[i].exp_err, vecs[i].exp_hold);
            if (vecs[i].exp_writes > 0 && got_data.size() > base)
                check($sformatf("vec%0d_w0", i), got_data[base], vecs[i].w0);
            if (vecs[i].exp_writes > 1 && got_data.size() > base + 1)
                check($sformatf("vec%0d_w1", i), got_data[base + 1], vecs[i].w1);
        end

        // write stall on word 0
        stall_req = 3;
        stall_tag++;
        sb = stall_seen;
        load_vec(0);
        run_frame("stall", 2, 1, 1'b0, 1'b0);
        check("stall_observed", (stall_seen - sb >= 3) ? 1 : 0, 1);

        // timeout after two data bytes
        frame.delete();
        frame.push_back(SYNC); frame.push_back(8'h02); frame.push_back(8'h00);
        frame.push_back(8'h11); frame.push_back(8'h22);
        for (int k = 0; k < frame.size(); k++) begin
            send_byte(frame[k]);
            if (k < frame.size() - 1) idle(7);
        end
        repeat (998) @(posedge clk);
        #1;
        check("timeout_not_early", err, 0);
        check("timeout_busy_before", busy, 1);
        @(posedge clk); #1;
        check("timeout_err", err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_hold", hold_cpu, 1);
        load_vec(0);
        run_frame("after_timeout", 2, 1, 1'b0, 1'b0);

        // reset while a write is pending in DATA
        stall_req = 100000;
        stall_tag++;
        frame.delete();
        frame.push_back(SYNC); frame.push_back(8'h02); frame.push_back(8'h00);
        for (int k = 1; k <= 5; k++) frame.push_back(8'(k));
        for (int k = 0; k < frame.size(); k++) begin
            send_byte(frame[k]);
            if (k < frame.size() - 1) idle(7);
        end
        check("midrst_pending", mem_we, 1);
        check("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, BASE);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_hold", hold_cpu, 1);
        stall_req = 0;
        stall_tag++;
        @(posedge clk); #1 rst = 1'b0;
        idle(3);
        load_vec(3);
        run_frame("after_rst", 1, 1, 1'b0, 1'b0);

        // random frames, some with corrupted checksum
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 4);
            g = $urandom_range(0, 2);
            frame.delete();
            for (int k = 0; k < g; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                frame.push_back(b);
            end
            frame.push_back(SYNC);
            frame.push_back(8'(n));
            frame.push_back(8'h00);
            x = 8'h00;
            for (int k = 0; k < 4 * n; k++) begin
                b = 8'($urandom_range(0, 255));
                frame.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'h5C;
            frame.push_back(x);
            model();
            run_frame($sformatf("rand%0d", r), exp_words.size(), exp_ok ? 1 : 0, !exp_ok, !exp_ok);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

Byte-stream boot loader that sits directly downstream of `uart_rx`. It consumes received bytes (`rx_data_valid` / `rx_data`) and parses a framed image: sync, length, little-endian 32-bit words, checksum. Each word is written to instruction/data memory through a simple valid/ready write port. The CPU is held in reset until a frame passes its checksum.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `TIMEOUT_CYCLES`, 1_000_000: maximum gap, in clk cycles, between bytes inside a frame.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_data_valid` in 1: one-cycle strobe from `uart_rx`; no backpressure.
- `rx_data` in 8: received byte, valid with the strobe.
- `mem_we` out 1: write request.
- `mem_addr` out 32: byte address, word aligned.
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: write accepted in any cycle where `mem_we && mem_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the frame is verified and all writes have completed.
- `err` out 1: sticky error flag.
- `hold_cpu` out 1: CPU reset request.

## Operation
- States: IDLE, LEN0, LEN1, DATA, CSUM, FINISH.
- IDLE:
  - Bytes other than `SYNC_BYTE` are ignored.
  - On `SYNC_BYTE`: clear `err`, set `hold_cpu`=1, reset the word index and XOR accumulator, go to LEN0.
- LEN0 / LEN1: capture word count N, LSB first, 16 bits. After LEN1, go to DATA if N≠0, otherwise CSUM.
- DATA:
  - Bytes are packed LSB first into a 32-bit shift register; a 2-bit byte counter tracks position.
  - Every data byte is XORed into the 8-bit accumulator.
  - On the 4th byte, the word is posted to the write port at `BASE_ADDR + 4*index`, and index increments (16-bit, no wrap since index < N).
  - After word N-1, go to CSUM.
- CSUM: the next byte is compared with the accumulator.
  - Match: go to FINISH.
  - Mismatch: set `err`, go to IDLE.
- FINISH: wait until no write is pending, then pulse `done`, clear `hold_cpu`, go to IDLE.
- Write port:
  - One-entry buffer. `mem_we`, `mem_addr` and `mem_wdata` are held stable until accepted.
  - A write, once issued, is never withdrawn, including on error abort.
- Overrun: a word completes while the previous write is still pending. Set `err`, drop the new word, go to IDLE.
- Timeout:
  - Gap counter clears on every `rx_data_valid` and counts in all non-IDLE states.
  - On reaching `TIMEOUT_CYCLES`: set `err`, go to IDLE.
  - FINISH is exempt from the timeout.
- Byte arriving in FINISH: treated as in IDLE after the `done` pulse; it is not dropped if it is `SYNC_BYTE`.
- Bytes during an error: ignored until the next `SYNC_BYTE`.

## Timing
- Reset values:
  - `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0.
  - `busy`=0, `done`=0, `err`=0, `hold_cpu`=1, state IDLE.
- All outputs are registered.
- 4th data byte strobe at cycle t → `mem_we`=1 at t+1.
- Accept at cycle a (`mem_we && mem_ready`) → `mem_we`=0 at a+1.
- Checksum strobe at t with no pending write → `done`=1 at t+1 and `hold_cpu`=0 at t+1.
- Pending write accepted at a → `done` at a+1.
- Timeout fires at the cycle where the counter equals `TIMEOUT_CYCLES`; `err`=1 on the next edge.
- `rst` mid-frame: all outputs go to reset values immediately. A pending write is abandoned.
- Minimum byte spacing assumed from `uart_rx`: 8 clk cycles.

## Test plan
- Normal two-word frame:
  - Stimulus: bytes A5 02 00 78 56 34 12 EF BE AD DE 2A.
  - Required: writes 0x12345678 @0x0, then 0xDEADBEEF @0x4; `done` pulses once; `hold_cpu` 1→0; `err`=0.
- Bad checksum:
  - Stimulus: same frame with checksum 2B.
  - Required: both writes occur; `err`=1; no `done`; `hold_cpu` stays 1.
- Garbage then empty frame:
  - Stimulus: 00 FF 5A, then A5 00 00 00.
  - Required: no writes; `done` pulse; `hold_cpu`=0.
- Write stall:
  - Stimulus: `mem_ready`=0 for 3 cycles on word 0.
  - Required: `mem_we`/`mem_addr`/`mem_wdata` stable throughout; exactly one accept; frame completes normally.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=1000; stop after 2 data bytes.
  - Required: `err`=1 exactly 1000 cycles after the last strobe; `busy`=0; a following good frame clears `err` and completes.
- Reset mid-DATA:
  - Stimulus: pulse `rst` after the 5th data byte.
  - Required: all outputs at reset values in the same cycle; the next frame loads from `BASE_ADDR`.
